// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared widths, default latency and FSM state encoding for the
//               data-memory line controller (INIT only with DMEM_RESET_CLEAR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

   localparam int LINE_W          = 256;
   localparam int ADDR_W          = 32;
   localparam int OFFSET_W        = 5;
   localparam int DEFAULT_LATENCY = 10;
   localparam int CNT_W           = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
`ifdef DMEM_RESET_CLEAR_EN
      ,
      INIT = 2'd3
`endif
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_line_array
// Description : DEPTH x 256-bit line storage, one synchronous write port and
//               one asynchronous read port; contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_line_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 512,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  waddr_i,
   input  logic [LINE_W-1:0] wdata_i,
   input  logic [IDX_W-1:0]  raddr_i,
   output logic [LINE_W-1:0] rdata_o
);

   logic [LINE_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         r_mem[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dmem_line_ctrl
// Description : Fixed-latency line fill / write-back controller in front of a
//               line array. Optional DMEM_RESET_CLEAR_EN zeroes all lines
//               after reset before the first request is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_line_ctrl
   import dmem_pkg::*;
#(
   parameter int LATENCY = DEFAULT_LATENCY,
   parameter int DEPTH   = 512
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic              write_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [LINE_W-1:0] data_i,
   output logic              ack_o,
   output logic [LINE_W-1:0] data_o
);

   localparam int               IDX_W        = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] C_COUNT_LOAD = CNT_W'(LATENCY - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_count;
   logic              r_write;
   logic [IDX_W-1:0]  r_idx;
   logic [LINE_W-1:0] r_wdata;
   logic [LINE_W-1:0] r_rdata;

   logic              w_accept;
   logic              w_load_rdata;
   logic              w_commit;
   logic              w_we;
   logic [IDX_W-1:0]  w_waddr;
   logic [LINE_W-1:0] w_wdata;
   logic [LINE_W-1:0] w_line;
   logic [IDX_W-1:0]  w_req_idx;
   logic              w_unused_addr;

`ifdef DMEM_RESET_CLEAR_EN
   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(DEPTH - 1);
   logic [IDX_W-1:0] r_init_idx;
   logic             w_init_we;
`endif

   // Upper bits alias lines modulo DEPTH; the byte offset is irrelevant.
   assign w_req_idx     = addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
   assign w_unused_addr = ^{addr_i[ADDR_W-1:IDX_W+OFFSET_W], addr_i[OFFSET_W-1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
`ifdef DMEM_RESET_CLEAR_EN
         r_state <= INIT;
`else
         r_state <= IDLE;
`endif
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_load_rdata = 1'b0;
      w_commit     = 1'b0;
      ack_o        = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
      w_init_we    = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (enable_i) begin
               w_accept    = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (r_count == '0) begin
               w_state_nxt  = ACK;
               w_load_rdata = ~r_write;
            end
         end
         ACK: begin
            // enable_i is deliberately not looked at here.
            ack_o       = 1'b1;
            w_commit    = r_write;
            w_state_nxt = IDLE;
         end
`ifdef DMEM_RESET_CLEAR_EN
         INIT: begin
            w_init_we = 1'b1;
            if (r_init_idx == C_LAST_IDX) begin
               w_state_nxt = IDLE;
            end
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_count <= '0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         if (w_accept) begin
            r_count <= C_COUNT_LOAD;
            r_write <= write_i;
            r_idx   <= w_req_idx;
            r_wdata <= data_i;
         end else if ((r_state == WAIT) && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
         end
         if (w_load_rdata) begin
            r_rdata <= w_line;
         end
      end
   end

`ifdef DMEM_RESET_CLEAR_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_init_idx <= '0;
      end else if (r_state == INIT) begin
         r_init_idx <= r_init_idx + 1'b1;
      end
   end
`endif

   always_comb begin
      w_we    = w_commit;
      w_waddr = r_idx;
      w_wdata = r_wdata;
`ifdef DMEM_RESET_CLEAR_EN
      if (w_init_we) begin
         w_we    = 1'b1;
         w_waddr = r_init_idx;
         w_wdata = '0;
      end
`endif
   end

   dmem_line_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (w_we),
      .waddr_i (w_waddr),
      .wdata_i (w_wdata),
      .raddr_i (r_idx),
      .rdata_o (w_line)
   );

   assign data_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_line_ctrl
// Description : Directed vector bench for dmem_line_ctrl (LATENCY=10 / DEPTH=512
//               main instance, LATENCY=1 / DEPTH=16 boundary instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_line_ctrl;
   import dmem_pkg::*;

   localparam int LAT = 10;
   localparam int DEP = 512;

   localparam logic [255:0] P0    = {8{32'h0000_F00D}};
   localparam logic [255:0] P2    = {8{32'h2222_0002}};
   localparam logic [255:0] P3    = {8{32'h3333_0003}};
   localparam logic [255:0] P4    = {8{32'h4444_0004}};
   localparam logic [255:0] P5    = {8{32'h5555_0005}};
   localparam logic [255:0] P7    = {8{32'h7777_0007}};
   localparam logic [255:0] P511  = {8{32'h1FF0_01FF}};
   localparam logic [255:0] PA5   = {32{8'hA5}};
   localparam logic [255:0] Q3    = {8{32'hC0DE_0033}};
   localparam logic [255:0] JUNK  = {8{32'hDEAD_BEEF}};
`ifdef DMEM_RESET_CLEAR_EN
   localparam logic [255:0] EXP5  = '0;
`else
   localparam logic [255:0] EXP5  = P5;
`endif

   logic         clk_i    = 1'b0;
   logic         rst_i    = 1'b1;
   logic         enable_i = 1'b0;
   logic         write_i  = 1'b0;
   logic [31:0]  addr_i   = '0;
   logic [255:0] data_i   = '0;
   logic         ack_o;
   logic [255:0] data_o;

   logic         en1   = 1'b0;
   logic         wr1   = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [255:0] din1  = '0;
   logic         ack1;
   logic [255:0] dout1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] exp;
   } vec_t;

   vec_t vecs [12];

   always #5 clk_i = ~clk_i;

   dmem_line_ctrl #(.LATENCY(LAT), .DEPTH(DEP)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .write_i  (write_i),
      .addr_i   (addr_i),
      .data_i   (data_i),
      .ack_o    (ack_o),
      .data_o   (data_o)
   );

   dmem_line_ctrl #(.LATENCY(1), .DEPTH(16)) dut1 (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (en1),
      .write_i  (wr1),
      .addr_i   (addr1),
      .data_i   (din1),
      .ack_o    (ack1),
      .data_o   (dout1)
   );

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b want %0b", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Counts rising edges until ack_o is seen; -1 when the bound expires.
   task automatic wait_ack(input int bound, output int n);
      n = 0;
      do begin
         @(posedge clk_i);
         #1;
         n++;
      end while (!ack_o && n < bound);
      if (!ack_o) n = -1;
   endtask

   // Must be entered just after a rising edge with the controller idle.
   task automatic txn(input string nm, input logic w, input logic [31:0] a,
                      input logic [255:0] d, input logic [255:0] exp);
      int n;
      enable_i = 1'b1;
      write_i  = w;
      addr_i   = a;
      data_i   = d;
      wait_ack(40, n);
      enable_i = 1'b0;
      chki({nm, " latency"}, n, LAT + 1);
      if (!w) chkd({nm, " data"}, data_o, exp);
      @(posedge clk_i);
      #1;
      chk1({nm, " ack width"}, ack_o, 1'b0);
      if (!w) chkd({nm, " data hold"}, data_o, exp);
   endtask

   initial begin
      int n;

      vecs[0]  = '{1'b1, 32'h0000_0040, P2,   '0};
      vecs[1]  = '{1'b0, 32'h0000_0040, JUNK, P2};
      vecs[2]  = '{1'b1, 32'h0000_0060, P3,   '0};
      vecs[3]  = '{1'b1, 32'h0000_0080, P4,   '0};
      vecs[4]  = '{1'b1, 32'h0000_00A0, P5,   '0};
      vecs[5]  = '{1'b1, 32'h0000_4000, P0,   '0};
      vecs[6]  = '{1'b0, 32'h0000_0000, JUNK, P0};
      vecs[7]  = '{1'b0, 32'h0000_401F, JUNK, P0};
      vecs[8]  = '{1'b1, 32'h0000_3FE0, P511, '0};
      vecs[9]  = '{1'b0, 32'hFFFF_FFE0, JUNK, P511};
      vecs[10] = '{1'b0, 32'h0000_0060, JUNK, P3};
      vecs[11] = '{1'b0, 32'h0000_0040, JUNK, P2};

      repeat (3) @(posedge clk_i);
      #1;
      chk1("reset ack", ack_o, 1'b0);
      chkd("reset data", data_o, '0);
      chk1("reset ack1", ack1, 1'b0);
      chkd("reset data1", dout1, '0);

`ifdef DMEM_RESET_CLEAR_EN
      @(negedge clk_i);
      rst_i    = 1'b0;
      enable_i = 1'b1;
      write_i  = 1'b0;
      addr_i   = 32'h0000_00E0;
      wait_ack(DEP + 40, n);
      enable_i = 1'b0;
      chki("init latency", n, DEP + LAT + 1);
      chkd("init cleared line", data_o, '0);
      @(posedge clk_i);
      #1;
`else
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
`endif

      for (int i = 0; i < 12; i++) begin
         txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
      end

      // Write-back with request held, then fill accepted in the next IDLE cycle.
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0400;
      data_i   = PA5;
      wait_ack(40, n);
      chki("b2b first latency", n, LAT + 1);
      write_i = 1'b0;
      wait_ack(40, n);
      enable_i = 1'b0;
      chki("b2b ack spacing", n, LAT + 2);
      chkd("b2b fill data", data_o, PA5);
      @(posedge clk_i);
      #1;
      chk1("b2b ack width", ack_o, 1'b0);

      // Request inputs change and enable drops after acceptance.
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_0060;
      data_i   = Q3;
      @(posedge clk_i);
      #1;
      enable_i = 1'b0;
      write_i  = 1'b0;
      addr_i   = 32'h0000_0080;
      data_i   = JUNK;
      wait_ack(40, n);
      chki("midflight latency", n, LAT);
      @(posedge clk_i);
      #1;
      txn("midflight line3", 1'b0, 32'h0000_0060, JUNK, Q3);
      txn("midflight line4", 1'b0, 32'h0000_0080, JUNK, P4);

      // Minimum latency on the small instance, plus aliasing at DEPTH=16.
      en1   = 1'b1;
      wr1   = 1'b1;
      addr1 = 32'h0000_0060;
      din1  = P7;
      n = 0;
      do begin @(posedge clk_i); #1; n++; end while (!ack1 && n < 20);
      en1 = 1'b0;
      chki("lat1 write latency", n, 2);
      @(posedge clk_i);
      #1;
      chk1("lat1 ack width", ack1, 1'b0);
      en1   = 1'b1;
      wr1   = 1'b0;
      addr1 = 32'h0000_0260;
      n = 0;
      do begin @(posedge clk_i); #1; n++; end while (!ack1 && n < 20);
      en1 = 1'b0;
      chki("lat1 read latency", n, 2);
      chkd("lat1 alias data", dout1, P7);
      @(posedge clk_i);
      #1;

      // Reset five cycles into a write drops it without committing.
      enable_i = 1'b1;
      write_i  = 1'b1;
      addr_i   = 32'h0000_00A0;
      data_i   = JUNK;
      repeat (5) @(posedge clk_i);
      #1;
      rst_i = 1'b1;
      #1;
      chk1("rst midwait ack", ack_o, 1'b0);
      chkd("rst midwait data", data_o, '0);
      enable_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk1("rst held ack", ack_o, 1'b0);
      @(negedge clk_i);
      rst_i = 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
      repeat (DEP + 2) @(posedge clk_i);
`endif
      @(posedge clk_i);
      #1;
      txn("post reset line5", 1'b0, 32'h0000_00A0, JUNK, EXP5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
